conv_mac_tree_acc: RTL and testbench

- Parametrised successor to the fixed 3x3 SIMD multiply-add unit.
- Computes a KERNEL_NUM-tap dot product for PICTURE_NUM pixel lanes that share one weight set, using a registered, balanced adder tree.
- Accumulates the per-beat sums across a group of input channels, delimited by first/last flags, and emits one result per group with a valid strobe.
- Sits between the line-buffer/window generator and the requant/activation stage.

---
 rtl/conv_mac_tree_acc.sv | 152 +++++++++++++++
 tb/tb_conv_mac_tree_acc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_tree_acc.sv
// rtl/conv_mac_tree_acc.sv - multi-lane dot product with registered adder tree and channel accumulator
// Define CONV_MAC_SATURATE_EN for a saturating accumulator and a per-lane out_sat flag.
module conv_mac_tree_acc #(
  parameter int KERNEL_NUM  = 9,
  parameter int PICTURE_NUM = 4,
  parameter int WIDTH_DATA  = 8,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  input  logic                                      in_first,
  input  logic                                      in_last,
  input  logic [PICTURE_NUM*KERNEL_NUM*WIDTH_DATA-1:0] data_in,
  input  logic [KERNEL_NUM*WIDTH_DATA-1:0]          weight_in,
  output logic                                      out_valid,
  output logic [PICTURE_NUM*ACC_WIDTH-1:0]          data_out,
  output logic [PICTURE_NUM-1:0]                    out_sat
);

  localparam int D  = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 0;
  localparam int PW = 2 * WIDTH_DATA;
  localparam int SW = PW + D;

  typedef enum logic {IDLE, ACC} state_t;

  function automatic int level_nodes(input int lvl);
    int n;
    n = KERNEL_NUM;
    for (int j = 0; j < lvl; j++) n = (n + 1) / 2;
    return n;
  endfunction

  logic signed [PW-1:0]        prod [PICTURE_NUM][KERNEL_NUM];
  // Inner dimension is doubled so the 2*i+1 child index never leaves the array.
  logic signed [SW-1:0]        node [PICTURE_NUM][D+1][2*KERNEL_NUM];
  logic [D:0]                  vld, fst, lst;
  logic signed [ACC_WIDTH-1:0] acc [PICTURE_NUM];
  logic signed [ACC_WIDTH-1:0] base [PICTURE_NUM];
  logic signed [ACC_WIDTH-1:0] acc_next [PICTURE_NUM];
  state_t                      state;

  always_comb begin
    for (int p = 0; p < PICTURE_NUM; p++) begin
      for (int i = 0; i < KERNEL_NUM; i++) begin
        prod[p][i] = PW'($signed(data_in[(i*PICTURE_NUM+p)*WIDTH_DATA +: WIDTH_DATA]))
                   * PW'($signed(weight_in[i*WIDTH_DATA +: WIDTH_DATA]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PICTURE_NUM; p++)
        for (int l = 0; l <= D; l++)
          for (int i = 0; i < 2*KERNEL_NUM; i++)
            node[p][l][i] <= '0;
      vld <= '0;
      fst <= '0;
      lst <= '0;
    end else begin
      vld[0] <= in_valid;
      fst[0] <= in_first;
      lst[0] <= in_last;
      for (int k = 1; k <= D; k++) begin
        vld[k] <= vld[k-1];
        fst[k] <= fst[k-1];
        lst[k] <= lst[k-1];
      end
      for (int p = 0; p < PICTURE_NUM; p++) begin
        for (int i = 0; i < KERNEL_NUM; i++) node[p][0][i] <= SW'(prod[p][i]);
        for (int l = 1; l <= D; l++) begin
          for (int i = 0; i < KERNEL_NUM; i++) begin
            if (i < level_nodes(l)) begin
              if (2*i + 1 < level_nodes(l-1))
                node[p][l][i] <= node[p][l-1][2*i] + node[p][l-1][2*i+1];
              else
                node[p][l][i] <= node[p][l-1][2*i];
            end
          end
        end
      end
    end
  end

  // Outside a group the held value lives in data_out, which equals the last acc.
  always_comb begin
    for (int p = 0; p < PICTURE_NUM; p++) begin
      base[p] = fst[D] ? '0 : ((state == ACC) ? acc[p] : $signed(data_out[p*ACC_WIDTH +: ACC_WIDTH]));
    end
  end

`ifdef CONV_MAC_SATURATE_EN
  localparam int EW = ((ACC_WIDTH > SW) ? ACC_WIDTH : SW) + 1;
  localparam logic signed [EW-1:0] MAXV = EW'({1'b0, {(ACC_WIDTH-1){1'b1}}});
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  logic signed [EW-1:0]   sum_ext [PICTURE_NUM];
  logic [PICTURE_NUM-1:0] sat_now, sat_acc, sat_new;

  always_comb begin
    for (int p = 0; p < PICTURE_NUM; p++) begin
      sum_ext[p] = EW'(base[p]) + EW'(node[p][D][0]);
      sat_now[p] = (sum_ext[p] > MAXV) || (sum_ext[p] < MINV);
      if (sum_ext[p] > MAXV)      acc_next[p] = MAXV[ACC_WIDTH-1:0];
      else if (sum_ext[p] < MINV) acc_next[p] = MINV[ACC_WIDTH-1:0];
      else                        acc_next[p] = sum_ext[p][ACC_WIDTH-1:0];
    end
    sat_new = (fst[D] ? '0 : sat_acc) | sat_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_acc <= '0;
      out_sat <= '0;
    end else if (vld[D]) begin
      sat_acc <= sat_new;
      if (lst[D]) out_sat <= sat_new;
    end
  end
`else
  always_comb begin
    for (int p = 0; p < PICTURE_NUM; p++) begin
      acc_next[p] = base[p] + ACC_WIDTH'(node[p][D][0]);
    end
  end

  assign out_sat = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      data_out  <= '0;
      for (int p = 0; p < PICTURE_NUM; p++) acc[p] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (vld[D]) begin
        for (int p = 0; p < PICTURE_NUM; p++) acc[p] <= acc_next[p];
        if (lst[D]) begin
          out_valid <= 1'b1;
          state     <= IDLE;
          for (int p = 0; p < PICTURE_NUM; p++) data_out[p*ACC_WIDTH +: ACC_WIDTH] <= acc_next[p];
        end else begin
          state <= ACC;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_tree_acc.sv
// tb/tb_conv_mac_tree_acc.sv - directed self-checking bench for conv_mac_tree_acc
module tb_conv_mac_tree_acc;
  localparam int K  = 9;
  localparam int P  = 4;
  localparam int W  = 8;
  localparam int A  = 32;
  localparam int A2 = 18;

  logic             clk;
  logic             rst_n;
  logic             in_valid, in_first, in_last;
  logic [P*K*W-1:0] data_in;
  logic [K*W-1:0]   weight_in;
  logic             out_valid, out_valid18;
  logic [P*A-1:0]   data_out;
  logic [P*A2-1:0]  data_out18;
  logic [P-1:0]     out_sat, out_sat18;

  int n_cmp = 0;
  int n_err = 0;

  conv_mac_tree_acc #(.KERNEL_NUM(K), .PICTURE_NUM(P), .WIDTH_DATA(W), .ACC_WIDTH(A)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .data_in(data_in), .weight_in(weight_in), .out_valid(out_valid), .data_out(data_out),
    .out_sat(out_sat)
  );

  conv_mac_tree_acc #(.KERNEL_NUM(K), .PICTURE_NUM(P), .WIDTH_DATA(W), .ACC_WIDTH(A2)) dut18 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .data_in(data_in), .weight_in(weight_in), .out_valid(out_valid18), .data_out(data_out18),
    .out_sat(out_sat18)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input int exp);
    logic [31:0] e;
    e = exp;
    for (int p = 0; p < P; p++) chk(tag, 64'(data_out[p*A +: A]), 64'(e));
  endtask

  task automatic chk_lanes18(input string tag, input int exp);
    logic [A2-1:0] e;
    e = exp[A2-1:0];
    for (int p = 0; p < P; p++) chk(tag, 64'(data_out18[p*A2 +: A2]), 64'(e));
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    data_in   = '0;
    weight_in = '0;
  endtask

  // First n taps carry data d / weight w on every lane; per-lane sum is n*d*w.
  task automatic beat(input int d, input int w, input int n, input bit f, input bit l);
    in_valid  = 1'b1;
    in_first  = f;
    in_last   = l;
    data_in   = '0;
    weight_in = '0;
    for (int i = 0; i < n; i++) begin
      weight_in[i*W +: W] = w[7:0];
      for (int p = 0; p < P; p++) data_in[(i*P+p)*W +: W] = d[7:0];
    end
  endtask

  // Called one edge after the last beat was sampled; ends on the strobe edge.
  task automatic lat(input string tag);
    for (int k = 1; k < 6; k++) begin
      chk({tag, "_early"}, 64'(out_valid), 64'(0));
      tick();
    end
    chk({tag, "_strobe"}, 64'(out_valid), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk_lanes("rst_data", 0);
    chk("rst_sat", 64'(out_sat), 64'(0));
    rst_n = 1'b1;
    tick();

    beat(1, 1, 9, 1'b1, 1'b1);
    tick();
    idle();
    lat("t1");
    chk_lanes("t1_data", 9);
    tick();
    chk("t1_strobe_len", 64'(out_valid), 64'(0));
    chk_lanes("t1_hold", 9);

    beat(-128, -128, 9, 1'b1, 1'b1);
    tick();
    idle();
    lat("t2");
    chk_lanes("t2_data", 147456);

    beat(1, 1, 9, 1'b1, 1'b0);
    tick();
    beat(2, 1, 9, 1'b0, 1'b0);
    tick();
    beat(-3, 1, 9, 1'b0, 1'b1);
    tick();
    idle();
    lat("t3");
    chk_lanes("t3_data", 0);
    tick();
    chk("t3_single", 64'(out_valid), 64'(0));

    for (int k = 1; k <= 4; k++) begin
      beat(k, 1, 1, 1'b1, 1'b1);
      tick();
    end
    idle();
    chk("t4_early4", 64'(out_valid), 64'(0));
    tick();
    chk("t4_early5", 64'(out_valid), 64'(0));
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk("t4_strobe", 64'(out_valid), 64'(1));
      chk_lanes("t4_data", k);
      tick();
    end
    chk("t4_end", 64'(out_valid), 64'(0));

    beat(1, 1, 9, 1'b1, 1'b0);
    tick();
    beat(1, 1, 9, 1'b1, 1'b1);
    tick();
    idle();
    lat("t_restart");
    chk_lanes("t_restart_data", 9);

    beat(-128, -128, 9, 1'b1, 1'b0);
    tick();
    beat(-128, -128, 9, 1'b0, 1'b1);
    tick();
    idle();
    lat("t5");
    chk("t5_valid18", 64'(out_valid18), 64'(1));
    chk_lanes("t5_data32", 294912);
    chk("t5_sat32", 64'(out_sat), 64'(0));
`ifdef CONV_MAC_SATURATE_EN
    chk_lanes18("t5_data18", 131071);
    chk("t5_sat18", 64'(out_sat18), 64'(4'hF));
`else
    chk_lanes18("t5_data18", 32768);
    chk("t5_sat18", 64'(out_sat18), 64'(0));
`endif

    beat(1, 1, 9, 1'b1, 1'b0);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 64'(out_valid), 64'(0));
    chk_lanes("t6_rst_data", 0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t6_dropped", 64'(out_valid), 64'(0));
      tick();
    end
    beat(5, 1, 1, 1'b1, 1'b1);
    tick();
    idle();
    lat("t6");
    chk_lanes("t6_data", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
